cache_way_controller: RTL and testbench

Next-generation cache controller for an N-way set-associative cache core. It accepts CPU read/write requests and evaluates a per-way hit vector and per-way line states from the cache datapath. It chooses a victim way on a miss, runs writeback, allocate and upgrade transactions toward the ACE controller, and updates line state per way. Adds over the single-way controller: way selection, victim replacement, ACE shared-response handling, transaction timeout, multi-hit and replay error detection.

---
 rtl/cache_pkg.sv | 39 +++
 rtl/cache_victim_select.sv | 47 ++++
 rtl/cache_way_controller.sv | 200 ++++++++++++++++++++
 tb/tb_cache_way_controller.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared encodings for the cache controller and datapath: line states,
// CPU opcodes, controller states and small line-state predicates.
package cache_pkg;

  typedef enum logic [2:0] {
    LS_UC = 3'b000,
    LS_UD = 3'b001,
    LS_SC = 3'b010,
    LS_SD = 3'b011,
    LS_I  = 3'b100
  } line_state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01
  } cpu_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_ALLOCATE,
    S_UPGRADE
  } ctrl_state_t;

  // Codes 100..111 all decode as I, so bit 2 alone marks an invalid line.
  function automatic logic is_invalid(input logic [2:0] s);
    return s[2];
  endfunction

  function automatic logic is_dirty(input logic [2:0] s);
    return !s[2] && s[0];
  endfunction

  function automatic logic is_unique(input logic [2:0] s);
    return !s[2] && !s[1];
  endfunction

endpackage

// File: rtl/cache_victim_select.sv
// Victim way choice: lowest-index invalid way, otherwise a round-robin
// pointer that steps only when it supplied the victim.
module cache_victim_select
  import cache_pkg::*;
#(
  parameter int NUM_WAYS    = 4,
  parameter int WAY_IDX_W   = $clog2(NUM_WAYS),
  parameter int WIDTH_STATE = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_WAYS*WIDTH_STATE-1:0] way_state,
  input  logic                            advance,
  output logic [WAY_IDX_W-1:0]            victim_way
);

  logic [WAY_IDX_W-1:0] rr_q, rr_d;
  logic [WAY_IDX_W-1:0] inv_idx;
  logic                 inv_found;

  always_comb begin
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (is_invalid(way_state[i*WIDTH_STATE +: WIDTH_STATE])) begin
        inv_found = 1'b1;
        inv_idx   = WAY_IDX_W'(i);
      end
    end
  end

  assign victim_way = inv_found ? inv_idx : rr_q;

  // Explicit wrap so non-power-of-two way counts never point past the last way.
  always_comb begin
    rr_d = rr_q;
    if (advance && !inv_found) begin
      rr_d = (rr_q == WAY_IDX_W'(NUM_WAYS - 1)) ? '0 : rr_q + WAY_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/cache_way_controller.sv
// N-way cache controller: lookup, victim writeback, allocate, upgrade and
// per-way state update, with ACE wait timeout and multi-hit/replay errors.
module cache_way_controller
  import cache_pkg::*;
#(
  parameter int NUM_WAYS       = 4,
  parameter int WAY_IDX_W      = $clog2(NUM_WAYS),
  parameter int WIDTH_STATE    = 3,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cpu_req_valid,
  input  logic [1:0]                      cpu_req_op,
  output logic                            cpu_req_ready,
  input  logic [NUM_WAYS-1:0]             hit_way,
  input  logic [NUM_WAYS*WIDTH_STATE-1:0] way_state,
  input  logic                            ace_ready,
  input  logic                            ace_shared,
  output logic                            read_req,
  output logic                            write_req,
  output logic                            invalid_req,
  output logic [WAY_IDX_W-1:0]            sel_way,
  output logic                            write_from_cpu,
  output logic                            write_from_interconnect,
  output logic                            state_we,
  output logic [WIDTH_STATE-1:0]          new_state,
  output logic                            cache_complete,
  output logic                            cache_error
);

  localparam int            CW         = (CNT_W < 1) ? 1 : CNT_W;
  localparam bit            TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] CNT_LAST   = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  ctrl_state_t          state_q, state_d;
  cpu_op_t              op_q, op_d;
  logic                 replay_q, replay_d;
  logic [WAY_IDX_W-1:0] way_q, way_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [WAY_IDX_W-1:0]   hit_idx, victim_way;
  logic [WIDTH_STATE-1:0] hit_state, victim_state;
  logic                   multi_hit, hit, timeout, rr_advance;

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (hit_way[i]) hit_idx = WAY_IDX_W'(i);
    end
  end

  assign multi_hit    = (hit_way & (hit_way - NUM_WAYS'(1))) != '0;
  assign hit_state    = way_state[hit_idx*WIDTH_STATE +: WIDTH_STATE];
  assign hit          = (|hit_way) && !is_invalid(hit_state);
  assign victim_state = way_state[victim_way*WIDTH_STATE +: WIDTH_STATE];
  // The limit cycle is the one in which the count would reach TIMEOUT_CYCLES.
  assign timeout      = TIMEOUT_EN && (cnt_q == CNT_LAST);
  assign rr_advance   = (state_q == S_LOOKUP) && !multi_hit && !hit && !replay_q;

  cache_victim_select #(
    .NUM_WAYS    (NUM_WAYS),
    .WAY_IDX_W   (WAY_IDX_W),
    .WIDTH_STATE (WIDTH_STATE)
  ) u_victim (
    .clk        (clk),
    .reset      (reset),
    .way_state  (way_state),
    .advance    (rr_advance),
    .victim_way (victim_way)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_READ;
      replay_q <= 1'b0;
      way_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      replay_q <= replay_d;
      way_q    <= way_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d                 = state_q;
    op_d                    = op_q;
    replay_d                = replay_q;
    way_d                   = way_q;
    cnt_d                   = '0;
    cpu_req_ready           = 1'b0;
    read_req                = 1'b0;
    write_req               = 1'b0;
    invalid_req             = 1'b0;
    sel_way                 = '0;
    write_from_cpu          = 1'b0;
    write_from_interconnect = 1'b0;
    state_we                = 1'b0;
    new_state               = '0;
    cache_complete          = 1'b0;
    cache_error             = 1'b0;

    case (state_q)
      S_IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid && (cpu_req_op == OP_READ || cpu_req_op == OP_WRITE)) begin
          op_d     = cpu_op_t'(cpu_req_op);
          replay_d = 1'b0;
          state_d  = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        sel_way = hit_idx;
        if (multi_hit) begin
          cache_complete = 1'b1;
          cache_error    = 1'b1;
          state_d        = S_IDLE;
        end else if (hit) begin
          if (op_q == OP_READ) begin
            cache_complete = 1'b1;
            state_d        = S_IDLE;
          end else if (is_unique(hit_state)) begin
            write_from_cpu = 1'b1;
            state_we       = 1'b1;
            new_state      = WIDTH_STATE'(LS_UD);
            cache_complete = 1'b1;
            state_d        = S_IDLE;
          end else begin
            way_d   = hit_idx;
            state_d = S_UPGRADE;
          end
        end else if (replay_q) begin
          // A fill should always be followed by a hit; anything else is fatal.
          cache_complete = 1'b1;
          cache_error    = 1'b1;
          state_d        = S_IDLE;
        end else begin
          way_d   = victim_way;
          state_d = is_dirty(victim_state) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        sel_way   = way_q;
        write_req = 1'b1;
        if (ace_ready) begin
          state_we  = 1'b1;
          new_state = WIDTH_STATE'(LS_I);
          state_d   = S_ALLOCATE;
        end else if (timeout) begin
          cache_complete = 1'b1;
          cache_error    = 1'b1;
          state_d        = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ALLOCATE: begin
        sel_way  = way_q;
        read_req = 1'b1;
        if (ace_ready) begin
          write_from_interconnect = 1'b1;
          state_we                = 1'b1;
          new_state               = ace_shared ? WIDTH_STATE'(LS_SC) : WIDTH_STATE'(LS_UC);
          replay_d                = 1'b1;
          state_d                 = S_LOOKUP;
        end else if (timeout) begin
          cache_complete = 1'b1;
          cache_error    = 1'b1;
          state_d        = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_UPGRADE: begin
        sel_way     = way_q;
        invalid_req = 1'b1;
        if (ace_ready) begin
          write_from_cpu = 1'b1;
          state_we       = 1'b1;
          new_state      = WIDTH_STATE'(LS_UD);
          cache_complete = 1'b1;
          state_d        = S_IDLE;
        end else if (timeout) begin
          cache_complete = 1'b1;
          cache_error    = 1'b1;
          state_d        = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_way_controller.sv
// Directed bench for cache_way_controller: one default instance plus one with
// a 4-cycle ACE timeout, both fed from the same stimulus.
module tb_cache_way_controller;

  localparam logic [2:0] UC = 3'b000, UD = 3'b001, SC = 3'b010, SD = 3'b011, LI = 3'b100;
  localparam logic [1:0] RD = 2'b00, WR = 2'b01;

  // Flag order: ready | read write invalid | wfc wfi we | complete error
  localparam logic [8:0] F_IDLE     = 9'b1_000_000_00;
  localparam logic [8:0] F_QUIET    = 9'b0_000_000_00;
  localparam logic [8:0] F_WR_HIT   = 9'b0_000_101_10;
  localparam logic [8:0] F_HIT      = 9'b0_000_000_10;
  localparam logic [8:0] F_ERR      = 9'b0_000_000_11;
  localparam logic [8:0] F_AL_WAIT  = 9'b0_100_000_00;
  localparam logic [8:0] F_AL_DONE  = 9'b0_100_011_00;
  localparam logic [8:0] F_AL_TO    = 9'b0_100_000_11;
  localparam logic [8:0] F_WB_WAIT  = 9'b0_010_000_00;
  localparam logic [8:0] F_WB_DONE  = 9'b0_010_001_00;
  localparam logic [8:0] F_UP_WAIT  = 9'b0_001_000_00;
  localparam logic [8:0] F_UP_DONE  = 9'b0_001_101_10;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req_valid;
  logic [1:0]  cpu_req_op;
  logic [3:0]  hit_way;
  logic [11:0] way_state;
  logic        ace_ready, ace_shared;

  logic       cpu_req_ready, read_req, write_req, invalid_req;
  logic [1:0] sel_way;
  logic       write_from_cpu, write_from_interconnect, state_we;
  logic [2:0] new_state;
  logic       cache_complete, cache_error;

  logic       cpu_req_ready_b, read_req_b, write_req_b, invalid_req_b;
  logic [1:0] sel_way_b;
  logic       write_from_cpu_b, write_from_interconnect_b, state_we_b;
  logic [2:0] new_state_b;
  logic       cache_complete_b, cache_error_b;

  logic [8:0] fa, fb;
  assign fa = {cpu_req_ready, read_req, write_req, invalid_req,
               write_from_cpu, write_from_interconnect, state_we, cache_complete, cache_error};
  assign fb = {cpu_req_ready_b, read_req_b, write_req_b, invalid_req_b,
               write_from_cpu_b, write_from_interconnect_b, state_we_b, cache_complete_b, cache_error_b};

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_way_controller dut (
    .clk(clk), .reset(reset), .cpu_req_valid(cpu_req_valid), .cpu_req_op(cpu_req_op),
    .cpu_req_ready(cpu_req_ready), .hit_way(hit_way), .way_state(way_state),
    .ace_ready(ace_ready), .ace_shared(ace_shared), .read_req(read_req),
    .write_req(write_req), .invalid_req(invalid_req), .sel_way(sel_way),
    .write_from_cpu(write_from_cpu), .write_from_interconnect(write_from_interconnect),
    .state_we(state_we), .new_state(new_state), .cache_complete(cache_complete),
    .cache_error(cache_error)
  );

  cache_way_controller #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .reset(reset), .cpu_req_valid(cpu_req_valid), .cpu_req_op(cpu_req_op),
    .cpu_req_ready(cpu_req_ready_b), .hit_way(hit_way), .way_state(way_state),
    .ace_ready(ace_ready), .ace_shared(ace_shared), .read_req(read_req_b),
    .write_req(write_req_b), .invalid_req(invalid_req_b), .sel_way(sel_way_b),
    .write_from_cpu(write_from_cpu_b), .write_from_interconnect(write_from_interconnect_b),
    .state_we(state_we_b), .new_state(new_state_b), .cache_complete(cache_complete_b),
    .cache_error(cache_error_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ws(input logic [2:0] s3, s2, s1, s0);
    return {s3, s2, s1, s0};
  endfunction

  task automatic issue(input logic [1:0] op, input logic [11:0] st);
    cpu_req_valid = 1'b1;
    cpu_req_op    = op;
    way_state     = st;
    tick();
    cpu_req_valid = 1'b0;
  endtask

  // Clean miss with no invalid way: the round-robin pointer picks exp_way.
  task automatic rr_miss(input int exp_way, input string tag);
    issue(RD, ws(UC, UC, UC, UC));
    hit_way = 4'b0000;
    #1 chk({tag, "_lookup"}, fa, F_QUIET);
    tick();
    ace_ready = 1'b1;
    #1 chk({tag, "_alloc_flags"}, fa, F_AL_DONE);
    chk({tag, "_alloc_way"}, sel_way, exp_way[1:0]);
    tick();
    ace_ready = 1'b0;
    hit_way   = 4'(1) << exp_way;
    #1 chk({tag, "_replay"}, fa, F_HIT);
    tick();
    hit_way = 4'b0000;
  endtask

  initial begin
    reset = 1'b1; cpu_req_valid = 1'b0; cpu_req_op = RD; hit_way = 4'b0000;
    way_state = ws(LI, LI, LI, LI); ace_ready = 1'b0; ace_shared = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1 chk("reset_flags", fa, F_IDLE);
    chk("reset_sel", sel_way, 2'd0);
    chk("reset_new_state", new_state, 3'd0);
    chk("reset_flags_to", fb, F_IDLE);

    // Write hit on a UC line in way 2
    cpu_req_valid = 1'b1; cpu_req_op = WR; way_state = ws(LI, UC, LI, LI);
    #1 chk("wr_hit_accept", fa, F_IDLE);
    tick();
    cpu_req_valid = 1'b0; hit_way = 4'b0100;
    #1 chk("wr_hit_flags", fa, F_WR_HIT);
    chk("wr_hit_sel", sel_way, 2'd2);
    chk("wr_hit_state", new_state, UD);
    tick();
    hit_way = 4'b0000;
    #1 chk("wr_hit_idle", fa, F_IDLE);

    // Read miss filling the invalid way 2, shared response, replay hit
    issue(RD, ws(UC, LI, UC, UC));
    #1 chk("rd_miss_lookup", fa, F_QUIET);
    tick();
    #1 chk("rd_miss_alloc_wait", fa, F_AL_WAIT);
    chk("rd_miss_alloc_sel", sel_way, 2'd2);
    tick();
    ace_ready = 1'b1; ace_shared = 1'b1;
    #1 chk("rd_miss_fill_flags", fa, F_AL_DONE);
    chk("rd_miss_fill_sel", sel_way, 2'd2);
    chk("rd_miss_fill_state", new_state, SC);
    tick();
    ace_ready = 1'b0; ace_shared = 1'b0; way_state = ws(UC, SC, UC, UC); hit_way = 4'b0100;
    #1 chk("rd_miss_replay", fa, F_HIT);
    chk("rd_miss_replay_sel", sel_way, 2'd2);
    tick();
    hit_way = 4'b0000;

    // Walk the round-robin pointer 0 -> 1 -> 2 -> 3
    rr_miss(0, "rr0");
    rr_miss(1, "rr1");
    rr_miss(2, "rr2");

    // Dirty miss with all ways UD: writeback then allocate on way 3
    issue(RD, ws(UD, UD, UD, UD));
    #1 chk("dirty_lookup", fa, F_QUIET);
    tick();
    #1 chk("dirty_wb_wait", fa, F_WB_WAIT);
    chk("dirty_wb_sel", sel_way, 2'd3);
    tick();
    ace_ready = 1'b1;
    #1 chk("dirty_wb_done", fa, F_WB_DONE);
    chk("dirty_wb_state", new_state, LI);
    tick();
    ace_ready = 1'b0;
    #1 chk("dirty_alloc_wait", fa, F_AL_WAIT);
    chk("dirty_alloc_sel", sel_way, 2'd3);
    tick();
    ace_ready = 1'b1;
    #1 chk("dirty_fill_flags", fa, F_AL_DONE);
    chk("dirty_fill_state", new_state, UC);
    tick();
    ace_ready = 1'b0; way_state = ws(UC, UD, UD, UD); hit_way = 4'b1000;
    #1 chk("dirty_replay", fa, F_HIT);
    chk("dirty_replay_sel", sel_way, 2'd3);
    tick();
    hit_way = 4'b0000;
    rr_miss(0, "rr_wrap");

    // Write hit on SD way 1: upgrade held for 5 cycles, then acknowledged
    issue(WR, ws(LI, LI, SD, LI));
    hit_way = 4'b0010;
    #1 chk("upg_lookup", fa, F_QUIET);
    tick();
    hit_way = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      #1 chk("upg_wait", fa, F_UP_WAIT);
      chk("upg_wait_sel", sel_way, 2'd1);
      tick();
    end
    ace_ready = 1'b1;
    #1 chk("upg_done", fa, F_UP_DONE);
    chk("upg_done_state", new_state, UD);
    chk("upg_done_sel", sel_way, 2'd1);
    tick();
    ace_ready = 1'b0;
    #1 chk("upg_idle", fa, F_IDLE);

    // Allocate timeout on the short-timeout instance
    issue(RD, ws(UC, UC, UC, LI));
    #1 chk("to_lookup", fb, F_QUIET);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1 chk("to_wait", fb, F_AL_WAIT);
      tick();
    end
    #1 chk("to_expire", fb, F_AL_TO);
    chk("to_expire_long", fa, F_AL_WAIT);
    tick();
    #1 chk("to_idle", fb, F_IDLE);
    chk("to_long_still_wait", fa, F_AL_WAIT);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 chk("reset_from_alloc", fa, F_IDLE);

    // Multi-hit error
    issue(RD, ws(LI, LI, UC, UC));
    hit_way = 4'b0011;
    #1 chk("multi_hit", fa, F_ERR);
    chk("multi_hit_no_we", state_we, 1'b0);
    tick();
    hit_way = 4'b0000;
    #1 chk("multi_hit_idle", fa, F_IDLE);

    // Unsupported opcode is dropped
    cpu_req_valid = 1'b1; cpu_req_op = 2'b10;
    tick();
    cpu_req_valid = 1'b0;
    #1 chk("bad_op_dropped", fa, F_IDLE);

    // Reset in the middle of a writeback
    issue(RD, ws(UD, UD, UD, UD));
    #1 chk("rst_wb_lookup", fa, F_QUIET);
    tick();
    #1 chk("rst_wb_wait", fa, F_WB_WAIT);
    chk("rst_wb_sel", sel_way, 2'd0);
    reset = 1'b1;
    tick();
    #1 chk("rst_wb_abort", fa, F_IDLE);
    chk("rst_wb_sel_clear", sel_way, 2'd0);
    reset = 1'b0;
    tick();
    #1 chk("rst_wb_no_pulse", fa, F_IDLE);

    // Hit on an invalid line is a miss; replay miss is an error
    issue(RD, ws(UC, UC, UC, LI));
    hit_way = 4'b0001;
    #1 chk("inv_hit_lookup", fa, F_QUIET);
    tick();
    hit_way = 4'b0000;
    #1 chk("inv_hit_alloc", fa, F_AL_WAIT);
    ace_ready = 1'b1;
    tick();
    ace_ready = 1'b0;
    #1 chk("replay_miss_err", fa, F_ERR);
    tick();
    #1 chk("replay_miss_idle", fa, F_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
